ring_monitor: RTL

Receive-side checker for the one-hot ring counter sequence. It samples a WIDTH-bit ring bus and checks that each qualified sample is the rotate-left successor of the previous one (0001→0010→0100→1000→0001). It reports the decoded bit position, lock status, per-event error pulses and a saturating error count. It sits at the consuming end of any ring-counter-driven bus and is used for in-system checking and by counter benches as a self-checking monitor.

---
 rtl/ring_pkg.sv | 24 ++
 rtl/onehot_dec.sv | 28 ++
 rtl/ring_monitor.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ring_pkg.sv
// Shared definitions for ring-counter producers and consumers.
package ring_pkg;

   // Widest ring the successor helper supports.
   localparam int RING_MAX_W = 64;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      ACQUIRE  = 2'd1,
      LOCKED   = 2'd2
   } ring_state_e;

   // Rotate-left successor of a w-bit ring value held in the low bits of v.
   function automatic logic [RING_MAX_W-1:0] ring_next(input logic [RING_MAX_W-1:0] v,
                                                        input int w);
      logic [RING_MAX_W-1:0] mask;
      logic [RING_MAX_W-1:0] r;
      mask = {RING_MAX_W{1'b1}} >> (RING_MAX_W - w);
      r    = (v << 1) & mask;
      r[0] = |(v & (RING_MAX_W'(1) << (w - 1)));
      return r;
   endfunction

endpackage

// File: rtl/onehot_dec.sv
// One-hot to binary encoder with a legality flag (exactly one bit set).
module onehot_dec #(
   parameter int WIDTH = 4,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] vec,
   output logic [IDX_W-1:0] idx,
   output logic             legal
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [CNT_W-1:0] ones;

   // Popcount and OR-encode; idx is only meaningful when legal.
   always_comb begin
      ones = '0;
      idx  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (vec[i]) begin
            ones = ones + CNT_W'(1);
            idx  = idx | IDX_W'(i);
         end
      end
      legal = (ones == CNT_W'(1));
   end

endmodule

// File: rtl/ring_monitor.sv
// Receive-side checker for a one-hot rotate-left ring sequence.
module ring_monitor
   import ring_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int LOCK_CNT = 2,
   parameter int ERR_W    = 8,
   localparam int IDX_W   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] ring_in,
   input  logic             clr_err,
   output logic [IDX_W-1:0] index,
   output logic             onehot_ok,
   output logic             locked,
   output logic             err,
   output logic [ERR_W-1:0] err_count
);

   localparam int RUN_W = $clog2(LOCK_CNT + 1);

   ring_state_e      state_q, state_d;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic [IDX_W-1:0] index_q, index_d;
   logic             onehot_ok_q, onehot_ok_d;
   logic             locked_q, locked_d;
   logic             err_q, err_d;
   logic [ERR_W-1:0] err_count_q, err_count_d;

   logic [IDX_W-1:0]      dec_idx;
   logic                  legal;
   logic [RING_MAX_W-1:0] succ_full;
   logic [WIDTH-1:0]      succ;
   logic                  match;
   logic [RUN_W:0]        run_inc;

   onehot_dec #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_dec (
      .vec   (ring_in),
      .idx   (dec_idx),
      .legal (legal)
   );

   assign succ_full = ring_next(RING_MAX_W'(prev_q), WIDTH);
   assign succ      = succ_full[WIDTH-1:0];
   assign match     = (ring_in == succ);
   assign run_inc   = {1'b0, run_q} + (RUN_W+1)'(1);

   // Sequence tracking, lock/error decisions and next output values.
   always_comb begin
      state_d     = state_q;
      prev_d      = prev_q;
      run_d       = run_q;
      index_d     = index_q;
      onehot_ok_d = onehot_ok_q;
      err_d       = 1'b0;
      if (en) begin
         onehot_ok_d = legal;
         if (legal) index_d = dec_idx;
         unique case (state_q)
            UNLOCKED: begin
               if (legal) begin
                  prev_d  = ring_in;
                  run_d   = '0;
                  state_d = ACQUIRE;
               end
            end
            ACQUIRE: begin
               // prev is always one-hot here, so match implies legal.
               if (match) begin
                  prev_d = ring_in;
                  run_d  = run_inc[RUN_W-1:0];
                  if (run_inc == (RUN_W+1)'(LOCK_CNT)) state_d = LOCKED;
               end else if (legal) begin
                  prev_d = ring_in;
                  run_d  = '0;
               end else begin
                  state_d = UNLOCKED;
               end
            end
            LOCKED: begin
               if (match) begin
                  prev_d = ring_in;
               end else begin
                  err_d = 1'b1;
                  if (legal) begin
                     prev_d  = ring_in;
                     run_d   = '0;
                     state_d = ACQUIRE;
                  end else begin
                     state_d = UNLOCKED;
                  end
               end
            end
            default: state_d = UNLOCKED;
         endcase
      end
      locked_d = (state_d == LOCKED);
      // Clear wins over a same-cycle increment; the err pulse itself still fires.
      if (clr_err)                             err_count_d = '0;
      else if (err_d && (err_count_q != '1))   err_count_d = err_count_q + ERR_W'(1);
      else                                     err_count_d = err_count_q;
   end

   // State and output registers, asynchronously cleared.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= UNLOCKED;
         prev_q      <= '0;
         run_q       <= '0;
         index_q     <= '0;
         onehot_ok_q <= 1'b0;
         locked_q    <= 1'b0;
         err_q       <= 1'b0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         prev_q      <= prev_d;
         run_q       <= run_d;
         index_q     <= index_d;
         onehot_ok_q <= onehot_ok_d;
         locked_q    <= locked_d;
         err_q       <= err_d;
         err_count_q <= err_count_d;
      end
   end

   assign index     = index_q;
   assign onehot_ok = onehot_ok_q;
   assign locked    = locked_q;
   assign err       = err_q;
   assign err_count = err_count_q;

endmodule
